// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter: one access per cycle from up to eight masters,
// fixed-priority or round-robin, with a bounded bus lock and in-order read return.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RD_LATENCY  = 1,
    parameter int RR_MODE     = 1,
    parameter int LOCK_MAX    = 160
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_MASTERS-1:0]        i_req,
    input  logic [NUM_MASTERS-1:0]        i_we,
    input  logic [NUM_MASTERS-1:0]        i_lock,
    input  logic [NUM_MASTERS*ADDR_W-1:0] i_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_wdata,
    output logic [NUM_MASTERS-1:0]        o_gnt,
    output logic [NUM_MASTERS-1:0]        o_rvalid,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [ADDR_W-1:0]             o_mem_rd_addr,
    output logic                          o_mem_wr_en,
    output logic [ADDR_W-1:0]             o_mem_wr_addr,
    output logic [DATA_W-1:0]             o_mem_wr_data,
    input  logic [DATA_W-1:0]             i_mem_rd_data
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [IDX_W-1:0]       rr_ptr;
    logic                   owner_vld;
    logic [IDX_W-1:0]       owner_id;
    logic [CNT_W-1:0]       lock_cnt;
    logic                   excl_vld;
    logic [IDX_W-1:0]       excl_id;

    logic [NUM_MASTERS-1:0] mask;
    logic                   owner_win;
    logic                   gnt_any;
    logic [IDX_W-1:0]       gnt_id;
    logic [NUM_MASTERS-1:0] gnt;

    logic [CNT_W-1:0]       lock_base;
    logic [CNT_W-1:0]       lock_next;
    logic                   lock_take;
    logic                   lock_done;

    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;

    logic [RD_LATENCY-1:0]  rd_vld_p;
    logic [IDX_W-1:0]       rd_id_p [RD_LATENCY];

    always_comb begin
        int idx;
        idx       = 0;
        mask      = i_req;
        if (excl_vld) begin
            mask[excl_id] = 1'b0;
        end
        owner_win = owner_vld && i_req[owner_id];
        gnt_any   = 1'b0;
        gnt_id    = '0;
        if (owner_win) begin
            gnt_any = 1'b1;
            gnt_id  = owner_id;
        end else if (RR_MODE != 0) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                idx = (int'(rr_ptr) + i) % NUM_MASTERS;
                if (!gnt_any && mask[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDX_W'(idx);
                end
            end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDX_W'(i);
                end
            end
        end
        // Grants are suppressed while reset is asserted, whatever the masters drive.
        gnt_any = gnt_any & i_rst_n;
        gnt     = '0;
        if (gnt_any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (gnt[m]) begin
                sel_addr  = sel_addr  | i_addr[m*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | i_wdata[m*DATA_W +: DATA_W];
            end
        end
    end

    assign o_gnt         = gnt;
    assign o_mem_rd_addr = sel_addr;
    assign o_mem_wr_addr = sel_addr;
    assign o_mem_wr_data = sel_wdata;
    assign o_mem_wr_en   = |(gnt & i_we);

    // A locked grant continues the owner's count; any other locked grant starts a new one.
    assign lock_base = (owner_vld && (owner_id == gnt_id)) ? lock_cnt : '0;
    assign lock_next = lock_base + CNT_W'(1);
    assign lock_take = gnt_any && i_lock[gnt_id];
    assign lock_done = lock_take && (lock_next == CNT_W'(LOCK_MAX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr    <= '0;
            owner_vld <= 1'b0;
            owner_id  <= '0;
            lock_cnt  <= '0;
            excl_vld  <= 1'b0;
            excl_id   <= '0;
            rd_vld_p  <= '0;
        end else begin
            if (gnt_any && !owner_win) begin
                rr_ptr <= IDX_W'((int'(gnt_id) + 1) % NUM_MASTERS);
            end
            excl_vld <= lock_done;
            excl_id  <= gnt_id;
            if (lock_take && !lock_done) begin
                owner_vld <= 1'b1;
                owner_id  <= gnt_id;
                lock_cnt  <= lock_next;
            end else begin
                owner_vld <= 1'b0;
                lock_cnt  <= '0;
            end
            // Stage p0: read tag of the current grant; later stages age it toward the tail.
            rd_vld_p[0] <= gnt_any && !i_we[gnt_id];
            for (int s = 1; s < RD_LATENCY; s++) begin
                rd_vld_p[s] <= rd_vld_p[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        rd_id_p[0] <= gnt_id;
        for (int s = 1; s < RD_LATENCY; s++) begin
            rd_id_p[s] <= rd_id_p[s-1];
        end
    end

    // Tail stage: route memory read data to the master that issued the read.
    always_comb begin
        o_rvalid = '0;
        o_rdata  = '0;
        if (rd_vld_p[RD_LATENCY-1]) begin
            o_rvalid[rd_id_p[RD_LATENCY-1]] = 1'b1;
            o_rdata                         = i_mem_rd_data;
        end
    end

endmodule
